dma_block_copier: RTL

Block-transfer sequencer sitting directly upstream of the DMA bus-access engine. Given a source address, destination address and byte count, it issues a stream of single-byte requests over the dma_req/dma_ack/dma_end handshake. Transfers proceed in bursts: it reads up to BURST bytes into a local buffer, then writes them back out. It reports busy/done to the control register file.

---
 rtl/dma_block_copier.sv | 356 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_block_copier.sv
// dma_block_copier
//
// Block-transfer sequencer placed in front of the DMA bus-access engine.
// A transfer of len bytes from src to dst runs in bursts. Up to BURST bytes
// are read into a local buffer, the bus is released, and the same bytes are
// then written out. Every access is a single-byte request on the
// dma_req/dma_ack/dma_end handshake.
//
// Optional feature macro: DMA_COPY_FILL_EN
//   When defined, the fill_i/fill_data_i ports exist. A start with fill_i=1
//   skips the read phases and writes fill_data_i to every destination byte.
//   When undefined, the block always copies.
//
// Parameters
//   BURST        buffer depth and maximum bytes per read or write phase
//                (power of two, 1..16)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start_i      one-clock pulse; latches src/dst/len; ignored while busy
//   abort_i      one-clock pulse; stops once outstanding accesses complete
//   src_i        source byte address (22 bits)
//   dst_i        destination byte address (22 bits)
//   len_i        byte count (16 bits); 0 means no transfer
//   fill_i       fill mode select, sampled at start (DMA_COPY_FILL_EN only)
//   fill_data_i  fill byte, sampled at start (DMA_COPY_FILL_EN only)
//   busy_o       transfer in progress
//   done_o       one-clock pulse when the transfer finishes or is aborted
//   aborted_o    set with done_o when abort ended the transfer
//   dma_req_o    request to the access engine (level)
//   dma_addr_o   request address
//   dma_rnw_o    1 = read, 0 = write
//   dma_wd_o     write data
//   dma_ack_i    engine latched addr/rnw/wd on this edge
//   dma_end_i    access complete; dma_rd_i valid during it
//   dma_rd_i     read data

module dma_block_copier #(
  parameter int unsigned BURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [21:0] src_i,
  input  logic [21:0] dst_i,
  input  logic [15:0] len_i,
`ifdef DMA_COPY_FILL_EN
  input  logic        fill_i,
  input  logic [7:0]  fill_data_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o,
  output logic        dma_req_o,
  output logic [21:0] dma_addr_o,
  output logic        dma_rnw_o,
  output logic [7:0]  dma_wd_o,
  input  logic        dma_ack_i,
  input  logic        dma_end_i,
  input  logic [7:0]  dma_rd_i
);

  // Counters must hold the value BURST itself; the buffer index only 0..BURST-1.
  localparam int unsigned CW    = $clog2(BURST) + 1;
  localparam int unsigned IW    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned DEPTH = 1 << IW;
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDRAIN,
    WR,
    WRDRAIN,
    FIN
  } copyState_t;

  copyState_t state_q, state_d;

  logic [21:0]   srcPtr_q, srcPtr_d;
  logic [21:0]   dstPtr_q, dstPtr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] ends_q, ends_d;
  logic          abortPend_q, abortPend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          dmaReq_q, dmaReq_d;
  logic [21:0]   dmaAddr_q, dmaAddr_d;
  logic          dmaRnw_q, dmaRnw_d;
  logic [7:0]    dmaWd_q, dmaWd_d;

  logic [7:0]    dataBuf_q [DEPTH];

  logic          ackHit;
  logic          endHit;
  logic          inBusy;
  logic [15:0]   remAfter;

  logic          startFill;
  logic [7:0]    startFillByte;
  logic          fillActive;
  logic [7:0]    fillValue;

`ifdef DMA_COPY_FILL_EN
  logic          fillMode_q, fillMode_d;
  logic [7:0]    fillByte_q, fillByte_d;

  assign startFill     = fill_i;
  assign startFillByte = fill_data_i;
  assign fillActive    = fillMode_q;
  assign fillValue     = fillByte_q;
`else
  assign startFill     = 1'b0;
  assign startFillByte = 8'h00;
  assign fillActive    = 1'b0;
  assign fillValue     = 8'h00;
`endif

  // Handshake pulses only mean something while a transfer is running; acks
  // are only expected in the request states, ends in any active phase.
  assign inBusy = (state_q == RD) || (state_q == RDRAIN) ||
                  (state_q == WR) || (state_q == WRDRAIN);
  assign ackHit = dma_ack_i && ((state_q == RD) || (state_q == WR));
  assign endHit = dma_end_i && inBusy;
  assign remAfter = remaining_q - 16'(chunk_q);

  function automatic logic [CW-1:0] chunkOf(input logic [15:0] rem);
    return (rem > 16'(BURST)) ? BURST_C : rem[CW-1:0];
  endfunction

  // Next-state logic for the sequencer. Pointers and counters advance on
  // every ack/end regardless of phase decisions, then the phase logic
  // decides whether to present the next request, drop the bus, or move on.
  // An abort drops the request immediately and holds the current state until
  // every acked access has ended; an ack may still land on the edge right
  // after the drop, so completion also waits for a quiet ack line.
  // The read-to-write change waits one clock after the last capture so the
  // first write byte comes from the buffer register, never from dma_rd_i.
  always_comb begin
    state_d     = state_q;
    srcPtr_d    = srcPtr_q;
    dstPtr_d    = dstPtr_q;
    remaining_d = remaining_q;
    chunk_d     = chunk_q;
    issued_d    = issued_q;
    ends_d      = ends_q;
    abortPend_d = abortPend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    dmaReq_d    = dmaReq_q;
    dmaAddr_d   = dmaAddr_q;
    dmaRnw_d    = dmaRnw_q;
    dmaWd_d     = dmaWd_q;
`ifdef DMA_COPY_FILL_EN
    fillMode_d  = fillMode_q;
    fillByte_d  = fillByte_q;
`endif

    if (ackHit) begin
      issued_d = issued_q + CW'(1);
      if (state_q == RD) begin
        srcPtr_d = srcPtr_q + 22'd1;
      end else begin
        dstPtr_d = dstPtr_q + 22'd1;
      end
    end
    if (endHit) begin
      ends_d = ends_q + CW'(1);
    end
    if (abort_i && inBusy) begin
      abortPend_d = 1'b1;
    end

    if (inBusy && abortPend_d) begin
      dmaReq_d = 1'b0;
      if (!dmaReq_q && !dma_ack_i && (ends_d == issued_d)) begin
        state_d = FIN;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            aborted_d   = 1'b0;
            busy_d      = 1'b1;
            srcPtr_d    = src_i;
            dstPtr_d    = dst_i;
            remaining_d = len_i;
            chunk_d     = chunkOf(len_i);
            issued_d    = '0;
            ends_d      = '0;
`ifdef DMA_COPY_FILL_EN
            fillMode_d  = fill_i;
            fillByte_d  = fill_data_i;
`endif
            if (len_i == 16'd0) begin
              state_d = FIN;
            end else if (startFill) begin
              state_d   = WR;
              dmaReq_d  = 1'b1;
              dmaRnw_d  = 1'b0;
              dmaAddr_d = dst_i;
              dmaWd_d   = startFillByte;
            end else begin
              state_d   = RD;
              dmaReq_d  = 1'b1;
              dmaRnw_d  = 1'b1;
              dmaAddr_d = src_i;
            end
          end
        end

        RD: begin
          if (ackHit) begin
            if (issued_d == chunk_q) begin
              dmaReq_d = 1'b0;
              state_d  = RDRAIN;
            end else begin
              dmaAddr_d = srcPtr_d;
            end
          end
        end

        RDRAIN: begin
          if (ends_q == chunk_q) begin
            state_d   = WR;
            issued_d  = '0;
            ends_d    = '0;
            dmaReq_d  = 1'b1;
            dmaRnw_d  = 1'b0;
            dmaAddr_d = dstPtr_q;
            dmaWd_d   = dataBuf_q[0];
          end
        end

        WR: begin
          if (ackHit) begin
            if (issued_d == chunk_q) begin
              dmaReq_d = 1'b0;
              state_d  = WRDRAIN;
            end else begin
              dmaAddr_d = dstPtr_d;
              dmaWd_d   = fillActive ? fillValue : dataBuf_q[issued_d[IW-1:0]];
            end
          end
        end

        WRDRAIN: begin
          if (ends_d == chunk_q) begin
            remaining_d = remAfter;
            if (remAfter != 16'd0) begin
              chunk_d  = chunkOf(remAfter);
              issued_d = '0;
              ends_d   = '0;
              dmaReq_d = 1'b1;
              if (fillActive) begin
                state_d   = WR;
                dmaRnw_d  = 1'b0;
                dmaAddr_d = dstPtr_q;
                dmaWd_d   = fillValue;
              end else begin
                state_d   = RD;
                dmaRnw_d  = 1'b1;
                dmaAddr_d = srcPtr_q;
              end
            end else begin
              state_d = FIN;
            end
          end
        end

        FIN: begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          aborted_d   = abortPend_q;
          abortPend_d = 1'b0;
          dmaReq_d    = 1'b0;
          dmaRnw_d    = 1'b1;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // All sequencer state and every output is registered here, so the bus
  // signals are stable for the whole cycle leading into each ack edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      srcPtr_q    <= '0;
      dstPtr_q    <= '0;
      remaining_q <= '0;
      chunk_q     <= '0;
      issued_q    <= '0;
      ends_q      <= '0;
      abortPend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      dmaReq_q    <= 1'b0;
      dmaAddr_q   <= '0;
      dmaRnw_q    <= 1'b1;
      dmaWd_q     <= '0;
`ifdef DMA_COPY_FILL_EN
      fillMode_q  <= 1'b0;
      fillByte_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      srcPtr_q    <= srcPtr_d;
      dstPtr_q    <= dstPtr_d;
      remaining_q <= remaining_d;
      chunk_q     <= chunk_d;
      issued_q    <= issued_d;
      ends_q      <= ends_d;
      abortPend_q <= abortPend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      dmaReq_q    <= dmaReq_d;
      dmaAddr_q   <= dmaAddr_d;
      dmaRnw_q    <= dmaRnw_d;
      dmaWd_q     <= dmaWd_d;
`ifdef DMA_COPY_FILL_EN
      fillMode_q  <= fillMode_d;
      fillByte_q  <= fillByte_d;
`endif
    end
  end

  // Read data is captured in arrival order; the end counter doubles as the
  // write index because ends return in the same order as the acks.
  always_ff @(posedge clk) begin
    if (endHit && ((state_q == RD) || (state_q == RDRAIN))) begin
      dataBuf_q[ends_q[IW-1:0]] <= dma_rd_i;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign aborted_o  = aborted_q;
  assign dma_req_o  = dmaReq_q;
  assign dma_addr_o = dmaAddr_q;
  assign dma_rnw_o  = dmaRnw_q;
  assign dma_wd_o   = dmaWd_q;

endmodule
